spi_response_router: RTL and testbench

//  Egress counterpart of the input arbitrator. Accepts one addressed stream {addr, payload} from the val/rdy SPI wrapper.

---
 rtl/spi_response_router_if.sv | 24 ++
 rtl/spi_response_router.sv | 99 +++++++++
 tb/tb_spi_response_router.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_response_router_if.sv
// Bundle between the SPI wrapper's egress stream and the routed per-output
// streams. The router takes the slave modport.
interface spi_response_router_if #(
  parameter int nbits       = 32,
  parameter int num_outputs = 6,
  parameter int addr_nbits  = $clog2(num_outputs)
);
  logic                        req_val;
  logic                        req_rdy;
  logic [addr_nbits+nbits-1:0] req_msg;
  logic                        resp_val [num_outputs];
  logic                        resp_rdy [num_outputs];
  logic [nbits-1:0]            resp_msg [num_outputs];

  modport master (
    output req_val, req_msg, resp_rdy,
    input  req_rdy, resp_val, resp_msg
  );

  modport slave (
    input  req_val, req_msg, resp_rdy,
    output req_rdy, resp_val, resp_msg
  );
endinterface

// File: rtl/spi_response_router.sv
// Routes an addressed {addr, payload} stream to one of num_outputs consumers,
// each behind a private 2-entry FIFO. SPI_ROUTER_DROP_COUNT_EN adds drop_count.
module spi_response_router #(
  parameter int nbits       = 32,
  parameter int num_outputs = 6,
  parameter int addr_nbits  = $clog2(num_outputs)
) (
  input  logic                          clk,
  input  logic                          reset,
  spi_response_router_if.slave          bus
`ifdef SPI_ROUTER_DROP_COUNT_EN
  ,
  output logic [7:0]                    drop_count
`endif
);

  localparam int unsigned           MW      = addr_nbits + nbits;
  localparam logic [addr_nbits:0]   NUM_OUT = (addr_nbits+1)'(num_outputs);

  logic [addr_nbits-1:0] addr;
  logic [nbits-1:0]      payload;
  logic                  addr_ok;
  logic                  sel_full;

  logic [nbits-1:0]      mem    [num_outputs][2];
  logic                  wr_ptr [num_outputs];
  logic                  rd_ptr [num_outputs];
  logic [1:0]            count  [num_outputs];
  logic                  enq    [num_outputs];
  logic                  deq    [num_outputs];

  assign addr    = bus.req_msg[MW-1 -: addr_nbits];
  assign payload = bus.req_msg[nbits-1:0];
  assign addr_ok = {1'b0, addr} < NUM_OUT;

  // Ready depends only on the addressed FIFO's current fill, never on a
  // same-cycle dequeue, so a full FIFO blocks even if its consumer drains now.
  always_comb begin
    sel_full = 1'b0;
    for (int i = 0; i < num_outputs; i++) begin
      if (addr == addr_nbits'(i) && count[i] == 2'd2) sel_full = 1'b1;
    end
  end

  assign bus.req_rdy = !addr_ok || !sel_full;

  always_comb begin
    for (int i = 0; i < num_outputs; i++) begin
      enq[i] = bus.req_val && addr_ok && (addr == addr_nbits'(i)) && (count[i] != 2'd2);
      deq[i] = (count[i] != 2'd0) && bus.resp_rdy[i];
    end
  end

  // FIFO state: storage is cleared on reset so resp_msg reads 0 afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < num_outputs; i++) begin
        count[i]  <= 2'd0;
        wr_ptr[i] <= 1'b0;
        rd_ptr[i] <= 1'b0;
        mem[i][0] <= '0;
        mem[i][1] <= '0;
      end
    end else begin
      for (int i = 0; i < num_outputs; i++) begin
        if (enq[i]) begin
          mem[i][wr_ptr[i]] <= payload;
          wr_ptr[i]         <= !wr_ptr[i];
        end
        if (deq[i]) rd_ptr[i] <= !rd_ptr[i];
        case ({enq[i], deq[i]})
          2'b10:   count[i] <= count[i] + 2'd1;
          2'b01:   count[i] <= count[i] - 2'd1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  for (genvar g = 0; g < num_outputs; g++) begin : g_out
    assign bus.resp_val[g] = (count[g] != 2'd0);
    assign bus.resp_msg[g] = mem[g][rd_ptr[g]];
  end

`ifdef SPI_ROUTER_DROP_COUNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= 8'd0;
    end else if (bus.req_val && !addr_ok) begin
      drop_count <= sat_inc8(drop_count);
    end
  end
`endif

endmodule

// File: tb/tb_spi_response_router.sv
// Bench for spi_response_router: vector table, corner-case sequences and a
// free-running queue scoreboard checked every cycle.
module tb_spi_response_router;
  localparam int NB = 32;
  localparam int NO = 6;
  localparam int AB = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_response_router_if #(.nbits(NB), .num_outputs(NO), .addr_nbits(AB)) bus ();

`ifdef SPI_ROUTER_DROP_COUNT_EN
  logic [7:0] drop_count;
`endif

  spi_response_router #(.nbits(NB), .num_outputs(NO), .addr_nbits(AB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef SPI_ROUTER_DROP_COUNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard: one expected-payload queue per output, updated as the
  // upcoming posedge will act on the currently driven inputs.
  logic [31:0] q [NO][$];
  bit          sb_en = 1'b0;
  int          m_drop = 0;
  logic [AB-1:0] sa;
  bit          sok;
  int          sn;
  bit          sacc;

  always @(negedge clk) begin
    if (sb_en) begin
      sa  = bus.req_msg[NB+AB-1:NB];
      sok = (int'(sa) < NO);
      if (sok) sn = q[sa].size(); else sn = 0;
      chk("sb_req_rdy", 32'(bus.req_rdy), (sn == 2) ? 32'd0 : 32'd1);
      for (int i = 0; i < NO; i++) begin
        chk($sformatf("sb_resp_val[%0d]", i), 32'(bus.resp_val[i]), 32'(q[i].size() != 0));
        if (q[i].size() != 0) chk($sformatf("sb_resp_msg[%0d]", i), bus.resp_msg[i], q[i][0]);
      end
`ifdef SPI_ROUTER_DROP_COUNT_EN
      chk("sb_drop_count", 32'(drop_count), 32'(m_drop));
`endif
      if (reset) begin
        for (int i = 0; i < NO; i++) q[i].delete();
        m_drop = 0;
      end else begin
        sacc = bus.req_val && sok && (sn < 2);
        for (int i = 0; i < NO; i++)
          if (q[i].size() != 0 && bus.resp_rdy[i]) void'(q[i].pop_front());
        if (sacc) q[sa].push_back(bus.req_msg[NB-1:0]);
        if (bus.req_val && !sok && m_drop < 255) m_drop++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [AB-1:0] a, input logic [31:0] d);
    bus.req_val = v;
    bus.req_msg = {a, d};
  endtask

  task automatic set_rdy(input logic [NO-1:0] m);
    for (int i = 0; i < NO; i++) bus.resp_rdy[i] = m[i];
  endtask

  function automatic logic [NO-1:0] vmask();
    logic [NO-1:0] m;
    for (int i = 0; i < NO; i++) m[i] = bus.resp_val[i];
    return m;
  endfunction

  typedef struct {
    bit            val;
    logic [AB-1:0] addr;
    logic [31:0]   data;
    bit            exp_rdy;
    logic [NO-1:0] exp_mask;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{1'b1, 3'd2, 32'hDEADBEEF, 1'b1, 6'h04};
    tbl[1] = '{1'b1, 3'd0, 32'h11111111, 1'b1, 6'h01};
    tbl[2] = '{1'b1, 3'd5, 32'h55555555, 1'b1, 6'h20};
    tbl[3] = '{1'b0, 3'd3, 32'h33333333, 1'b1, 6'h00};
    tbl[4] = '{1'b1, 3'd7, 32'h00000001, 1'b1, 6'h00};
    tbl[5] = '{1'b1, 3'd1, 32'hA5A5A5A5, 1'b1, 6'h02};
    tbl[6] = '{1'b1, 3'd6, 32'h00000002, 1'b1, 6'h00};
    tbl[7] = '{1'b1, 3'd4, 32'h0F0F0F0F, 1'b1, 6'h10};

    reset = 1'b1;
    drive(0, 3'd0, 32'h0);
    set_rdy('1);
    step();
    sb_en = 1'b1;
    step();
    reset = 1'b0;

    @(negedge clk);
    chk("reset_resp_val", 32'(vmask()), 32'd0);
    chk("reset_req_rdy", 32'(bus.req_rdy), 32'd1);
    for (int i = 0; i < NO; i++) chk($sformatf("reset_resp_msg[%0d]", i), bus.resp_msg[i], 32'd0);
    step();

    // single-cycle vectors, all consumers ready
    for (int k = 0; k < 8; k++) begin
      drive(tbl[k].val, tbl[k].addr, tbl[k].data);
      @(negedge clk);
      chk($sformatf("tbl%0d_req_rdy", k), 32'(bus.req_rdy), 32'(tbl[k].exp_rdy));
      step();
      drive(0, 3'd0, 32'h0);
      @(negedge clk);
      chk($sformatf("tbl%0d_resp_val", k), 32'(vmask()), 32'(tbl[k].exp_mask));
      if (tbl[k].exp_mask != '0)
        chk($sformatf("tbl%0d_resp_msg", k), bus.resp_msg[tbl[k].addr], tbl[k].data);
      step();
    end

    // stalled output 4 fills and blocks, other outputs still flow
    set_rdy(6'b101111);
    drive(1, 3'd4, 32'hAAAA0001); step();
    drive(1, 3'd4, 32'hBBBB0002); step();
    drive(1, 3'd4, 32'hCCCC0003);
    @(negedge clk); chk("blk_c_rdy0", 32'(bus.req_rdy), 32'd0);
    step();
    @(negedge clk); chk("blk_c_rdy1", 32'(bus.req_rdy), 32'd0);
    step();
    drive(1, 3'd1, 32'h12345678);
    @(negedge clk); chk("blk_x_rdy", 32'(bus.req_rdy), 32'd1);
    step();
    drive(0, 3'd0, 32'h0);
    @(negedge clk);
    chk("blk_x_val", 32'(bus.resp_val[1]), 32'd1);
    chk("blk_x_msg", bus.resp_msg[1], 32'h12345678);
    chk("blk_a_hold", bus.resp_msg[4], 32'hAAAA0001);
    step();
    set_rdy('1);
    @(negedge clk); chk("blk_a_msg", bus.resp_msg[4], 32'hAAAA0001);
    step();
    @(negedge clk); chk("blk_b_msg", bus.resp_msg[4], 32'hBBBB0002);
    step();
    @(negedge clk); chk("blk_empty", 32'(bus.resp_val[4]), 32'd0);
    step();

    // simultaneous enqueue and dequeue on output 3
    set_rdy(6'b110111);
    drive(1, 3'd3, 32'h0000000F); step();
    drive(1, 3'd3, 32'h0000001F);
    set_rdy('1);
    @(negedge clk);
    chk("sim_p_msg", bus.resp_msg[3], 32'h0000000F);
    chk("sim_rdy", 32'(bus.req_rdy), 32'd1);
    step();
    drive(0, 3'd0, 32'h0);
    set_rdy(6'b110111);
    @(negedge clk);
    chk("sim_q_val", 32'(bus.resp_val[3]), 32'd1);
    chk("sim_q_msg", bus.resp_msg[3], 32'h0000001F);
    step();
    @(negedge clk); chk("sim_q_stable", bus.resp_msg[3], 32'h0000001F);
    set_rdy('1);
    step();
    @(negedge clk); chk("sim_drained", 32'(bus.resp_val[3]), 32'd0);
    step();

    // invalid addresses are consumed and dropped
    reset = 1'b1; step(); reset = 1'b0;
    drive(1, 3'd7, 32'h1);
    @(negedge clk); chk("inv7_rdy", 32'(bus.req_rdy), 32'd1);
    step();
    drive(1, 3'd6, 32'h2);
    @(negedge clk); chk("inv6_rdy", 32'(bus.req_rdy), 32'd1);
    step();
    drive(0, 3'd0, 32'h0);
    @(negedge clk);
    chk("inv_no_val", 32'(vmask()), 32'd0);
`ifdef SPI_ROUTER_DROP_COUNT_EN
    chk("drop_two", 32'(drop_count), 32'd2);
`endif
    step();
    for (int k = 0; k < 300; k++) begin
      drive(1, 3'(6 + (k % 2)), 32'(k));
      step();
    end
    drive(0, 3'd0, 32'h0);
    @(negedge clk);
    chk("inv_many_no_val", 32'(vmask()), 32'd0);
`ifdef SPI_ROUTER_DROP_COUNT_EN
    chk("drop_sat", 32'(drop_count), 32'd255);
`endif
    step();

    // reset with buffered data in outputs 0 and 5
    set_rdy(6'b011110);
    drive(1, 3'd0, 32'h00000A01); step();
    drive(1, 3'd0, 32'h00000A02); step();
    drive(1, 3'd5, 32'h00000F01); step();
    drive(1, 3'd5, 32'h00000F02); step();
    drive(1, 3'd0, 32'h00000A03);
    @(negedge clk);
    chk("fill_rdy0", 32'(bus.req_rdy), 32'd0);
    chk("fill_vals", 32'(vmask()), 32'h21);
    step();
    drive(0, 3'd0, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_val", 32'(vmask()), 32'd0);
    chk("rst_mid_rdy", 32'(bus.req_rdy), 32'd1);
    for (int i = 0; i < NO; i++) chk($sformatf("rst_mid_msg[%0d]", i), bus.resp_msg[i], 32'd0);
    set_rdy('1);
    step();
    @(negedge clk); chk("rst_no_stale", 32'(vmask()), 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
